// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU_64 between the execute stage (req0) and the aux unit (req1).
// Define ALU_ARB_CC_EN to build the ZF/SF/OF condition-code register for requester-0 operations.
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_opcode,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_opcode,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [1:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             gnt0, gnt1;

    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_res_d    = rsp_res_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_zero_d   = rsp_zero_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    op_d         = gnt1 ? req1_opcode : req0_opcode;
                    a_d          = gnt1 ? req1_a : req0_a;
                    b_d          = gnt1 ? req1_b : req0_b;
                    owner_d      = gnt1;
                    last_grant_d = gnt1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = owner_q;
                rsp_res_d   = alu_res;
                rsp_ovf_d   = alu_overflow;
                rsp_zero_d  = alu_zero;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_res_q    <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_res_q    <= rsp_res_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign alu_opcode   = op_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_res      = rsp_res_q;
    assign rsp_overflow = rsp_ovf_q;
    assign rsp_zero     = rsp_zero_q;

`ifdef ALU_ARB_CC_EN
    // {zf, sf, of}; only execute-stage results touch the condition codes.
    logic [2:0] cc_q, cc_d;

    always_comb begin
        cc_d = cc_q;
        if (state_q == EXEC && !owner_q) begin
            cc_d = {alu_zero, alu_res[WIDTH-1], alu_overflow};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q <= '0;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign cc_zf = cc_q[2];
    assign cc_sf = cc_q[1];
    assign cc_of = cc_q[0];
`else
    assign cc_zf = 1'b0;
    assign cc_sf = 1'b0;
    assign cc_of = 1'b0;
`endif

endmodule
